// File: rtl/reg_buggy_pkg.sv
// Shared config_reg types: register map, arbiter FSM states and boot-time defaults.
// The boot table is only consumed when CFG_ARB_BOOT_INIT_EN is defined.
package reg_buggy_pkg;

  typedef enum logic [2:0] {
    adc0_reg, adc1_reg, temp_sensor0_reg, temp_sensor1_reg,
    analog_test, digital_test, amp_gain, digital_config
  } address_t;

  typedef enum logic [1:0] {BOOT, IDLE, ISSUE, RESP} cfg_arb_state_t;

  // Indexed by address_t
  localparam logic [15:0] CFG_BOOT_VALUES [8] = '{
    16'h0800, 16'h0800, 16'h0010, 16'h0010,
    16'h0000, 16'h0000, 16'h0004, 16'h0001
  };

  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_reg_arbiter_if.sv
// Requester-side request/response bundle of cfg_reg_arbiter.
interface cfg_arb_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/cfg_reg_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search starts one past last_grant and wraps.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant
);
  int best;
  int best_d;
  int d;

  // Distance from the slot after last_grant; smallest requesting distance wins.
  always_comb begin
    best   = 0;
    best_d = NUM_REQ;
    d      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
      if (req[i] && d < best_d) begin
        best_d = d;
        best   = i;
      end
    end
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++)
      grant[i] = en && (best_d < NUM_REQ) && (best == i);
  end
endmodule

// File: rtl/cfg_reg_arbiter.sv
// Shares the config_reg write/address port between NUM_REQ requesters, one access per 3 cycles.
// Define CFG_ARB_BOOT_INIT_EN to load CFG_BOOT_VALUES into all addresses after reset.
module cfg_reg_arbiter
  import reg_buggy_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  cfg_arb_if.slave          bus,
  output logic              cfg_write,
  output logic [ADDR_W-1:0] cfg_address,
  output logic [DATA_W-1:0] cfg_data_in,
  input  logic [DATA_W-1:0] cfg_data_out,
  output logic              busy
);
  localparam int IDX_W = idx_w(NUM_REQ);

`ifdef CFG_ARB_BOOT_INIT_EN
  localparam cfg_arb_state_t RST_STATE = BOOT;
`else
  localparam cfg_arb_state_t RST_STATE = IDLE;
`endif

  cfg_arb_state_t      state_q, state_d;
  logic [IDX_W-1:0]    owner_q, last_grant_q, win_idx;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [NUM_REQ-1:0]  grant;
  logic                hs;

  // Gating with reset keeps req_ready low while reset is held in IDLE.
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .en         (state_q == IDLE && reset),
    .grant      (grant)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) win_idx = IDX_W'(i);
  end

  assign hs = |grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RST_STATE;
    else        state_q <= state_d;
  end

  // addr_q doubles as the boot address counter, so cfg_address holds its last value everywhere.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      wr_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else if (state_q == IDLE && hs) begin
      owner_q      <= win_idx;
      last_grant_q <= win_idx;
      wr_q         <= bus.req_write[win_idx];
      addr_q       <= bus.req_addr[win_idx];
      data_q       <= bus.req_wdata[win_idx];
    end
`ifdef CFG_ARB_BOOT_INIT_EN
    else if (state_q == BOOT && addr_q != '1) begin
      addr_q <= addr_q + ADDR_W'(1);
    end
`endif
  end

  always_comb begin
    state_d       = state_q;
    cfg_write     = 1'b0;
    cfg_data_in   = '0;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = grant;
        if (hs) state_d = ISSUE;
      end
      ISSUE: begin
        cfg_write   = wr_q;
        cfg_data_in = data_q;
        state_d     = RESP;
      end
      RESP: begin
        bus.rsp_valid[owner_q] = 1'b1;
        bus.rsp_rdata          = wr_q ? '0 : cfg_data_out;
        state_d                = IDLE;
      end
`ifdef CFG_ARB_BOOT_INIT_EN
      BOOT: begin
        cfg_write   = 1'b1;
        cfg_data_in = DATA_W'(CFG_BOOT_VALUES[addr_q]);
        if (addr_q == '1) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign cfg_address = addr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Randomized requester traffic against a register-content / round-robin reference model.
// Covers the CFG_ARB_BOOT_INIT_EN boot sequence when that macro is defined.
module tb_cfg_reg_arbiter;
  import reg_buggy_pkg::*;

  localparam int NR = 2;
  localparam int DW = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cfg_arb_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();
  logic          cfg_write;
  logic [AW-1:0] cfg_address;
  logic [DW-1:0] cfg_data_in;
  logic [DW-1:0] cfg_data_out = '0;
  logic          busy;

  cfg_reg_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .cfg_write    (cfg_write),
    .cfg_address  (cfg_address),
    .cfg_data_in  (cfg_data_in),
    .cfg_data_out (cfg_data_out),
    .busy         (busy)
  );

  // config_reg stand-in: synchronous write, registered read
  logic [DW-1:0] mem [8];
  always @(posedge clk) begin
    if (cfg_write) mem[cfg_address] <= cfg_data_in;
    cfg_data_out <= mem[cfg_address];
  end

  // Reference model: expected register contents and requester queue state
  logic [DW-1:0] ref_mem [8];
  logic [DW-1:0] boot_tab [8] = '{16'h0800, 16'h0800, 16'h0010, 16'h0010,
                                  16'h0000, 16'h0000, 16'h0004, 16'h0001};
  int            last_g;
  bit            pend [NR];
  bit            pw   [NR];
  logic [AW-1:0] pa   [NR];
  logic [DW-1:0] pd   [NR];
  int n_vec = 0;
  int n_err = 0;
`ifdef CFG_ARB_BOOT_INIT_EN
  localparam bit BUSY_RST = 1'b1;
`else
  localparam bit BUSY_RST = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i] = pend[i];
      bus.req_write[i] = pw[i];
      bus.req_addr[i]  = pa[i];
      bus.req_wdata[i] = pd[i];
    end
  endtask

  task automatic set_req(input int r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[r] = 1'b1; pw[r] = w; pa[r] = a; pd[r] = d;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.req_ready, 0);
    chk({tag, "_rspv"},  bus.rsp_valid, 0);
    chk({tag, "_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_cwr"},   cfg_write, 0);
    chk({tag, "_caddr"}, cfg_address, 0);
    chk({tag, "_cdin"},  cfg_data_in, 0);
    chk({tag, "_busy"},  busy, 32'(BUSY_RST));
  endtask

  // Called at a negedge with the DUT in IDLE; returns the granted requester or -1.
  task automatic round(output int win);
    bit w; logic [AW-1:0] a; logic [DW-1:0] d;
    drive_bus(); #1;
    win = -1;
    for (int off = 1; off <= NR; off++) begin
      int c;
      c = (last_g + off) % NR;
      if (pend[c] && win < 0) win = c;
    end
    if (win < 0) begin
      chk("idle_ready", bus.req_ready, 0);
      chk("idle_busy", busy, 0);
      @(negedge clk);
      return;
    end
    w = pw[win]; a = pa[win]; d = pd[win];
    chk("grant", bus.req_ready, 32'(1) << win);
    @(negedge clk);
    pend[win] = 1'b0; drive_bus(); #1;
    chk("iss_wr", cfg_write, 32'(w));
    chk("iss_addr", cfg_address, 32'(a));
    chk("iss_din", cfg_data_in, 32'(d));
    chk("iss_ready", bus.req_ready, 0);
    chk("iss_rspv", bus.rsp_valid, 0);
    chk("iss_busy", busy, 1);
    @(negedge clk); #1;
    chk("rsp_valid", bus.rsp_valid, 32'(1) << win);
    chk("rsp_rdata", bus.rsp_rdata, w ? 32'(0) : 32'(ref_mem[a]));
    chk("rsp_cwr", cfg_write, 0);
    chk("rsp_ready", bus.req_ready, 0);
    if (w) ref_mem[a] = d;
    last_g = win;
    @(negedge clk);
  endtask

  // Reset released at a negedge; leaves the bench at a negedge with the DUT in IDLE.
  task automatic post_reset();
    last_g = NR - 1;
`ifdef CFG_ARB_BOOT_INIT_EN
    set_req(1, 1'b0, AW'(adc1_reg), 16'h0);
    drive_bus(); #1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk("boot_busy", busy, 1);
      chk("boot_ready", bus.req_ready, 0);
      chk("boot_wr", cfg_write, 1);
      chk("boot_addr", cfg_address, 32'(k));
      chk("boot_din", cfg_data_in, 32'(boot_tab[k]));
    end
    for (int k = 0; k < 8; k++) ref_mem[k] = boot_tab[k];
    @(negedge clk);
`else
    @(negedge clk);
`endif
  endtask

  initial begin
    int win;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 8; i++) begin
      mem[i] = 16'h1000 + 16'(i);
      ref_mem[i] = 16'h1000 + 16'(i);
    end
    for (int i = 0; i < NR; i++) begin pend[i] = 0; pw[i] = 0; pa[i] = '0; pd[i] = '0; end

    // Reset values, with a requester already valid
    set_req(0, 1'b1, AW'(amp_gain), 16'h5555);
    drive_bus();
    repeat (2) @(negedge clk);
    #1 check_reset_vals("por");
    pend[0] = 1'b0; drive_bus();
    @(negedge clk);
    reset = 1'b1;
    post_reset();

`ifdef CFG_ARB_BOOT_INIT_EN
    set_req(0, 1'b0, AW'(adc0_reg), 16'($urandom));
    while (pend[0] || pend[1]) round(win);
`endif

    // Single write then read-back
    set_req(0, 1'b1, AW'(amp_gain), 16'h1A2B);
    round(win);
    chk("wr_owner", 32'(win), 0);
    set_req(1, 1'b0, AW'(amp_gain), 16'($urandom));
    round(win);
    chk("rd_owner", 32'(win), 1);

    // Contention: both valid, grants alternate
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < NR; r++)
        if (!pend[r]) set_req(r, 1'($urandom), AW'($urandom_range(7)), 16'($urandom));
      round(win);
      chk("alternate", 32'(win), 32'(t % 2));
    end

    // Random traffic, including idle cycles
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < NR; r++)
        if (!pend[r] && $urandom_range(1) == 1)
          set_req(r, 1'($urandom), AW'($urandom_range(7)), 16'($urandom));
      round(win);
    end
    while (pend[0] || pend[1]) round(win);

    // Reset during ISSUE of a write
    set_req(0, 1'b1, AW'(digital_test), 16'hBEEF);
    drive_bus(); #1;
    chk("mid_grant", bus.req_ready, 1);
    @(negedge clk);
    pend[0] = 1'b0; drive_bus(); #1;
    chk("mid_issue", cfg_write, 1);
    reset = 1'b0;
    #1 check_reset_vals("mid");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_no_rsp", bus.rsp_valid, 0);
    end
    reset = 1'b1;
    post_reset();
    while (pend[0] || pend[1]) round(win);

    // Recovery: requester 0 wins first, dropped write left no trace
    set_req(0, 1'b0, AW'(digital_test), 16'($urandom));
    set_req(1, 1'b0, AW'(digital_test), 16'($urandom));
    round(win);
    chk("rst_first", 32'(win), 0);
    round(win);
    chk("rst_second", 32'(win), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
